// File: rtl/muldiv_unit.sv
// muldiv_unit
// ----------------------------------------------------------------------------
// Sequential multiply/divide unit that owns the architectural HI/LO pair.
// Handles MULT, MULTU, DIV, DIVU (fixed 33-cycle latency after the accepting
// edge) and the MTHI/MTLO moves. Signed operations run unsigned on operand
// magnitudes and fix up the signs in a final FIX cycle.
//
// Ports
//   clk    in   1   rising-edge clock
//   reset  in   1   synchronous, active-high reset
//   start  in   1   begin an operation (sampled only in IDLE)
//   op     in   2   00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   a      in  32   rs operand: multiplicand / dividend / MTHI-MTLO data
//   b      in  32   rt operand: multiplier / divisor
//   mthi   in   1   HI := a (IDLE, no start)
//   mtlo   in   1   LO := a (IDLE, no start)
//   hi     out 32   HI register
//   lo     out 32   LO register
//   busy   out  1   operation in progress
//   done   out  1   one-cycle pulse after HI/LO are written by an operation
// ----------------------------------------------------------------------------
module muldiv_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        mthi,
  input  logic        mtlo,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [4:0]  r_cnt;
  logic        r_is_div;
  logic        r_sa;      // dividend / multiplicand negative (signed ops only)
  logic        r_sb;      // divisor / multiplier negative (signed ops only)
  logic [31:0] r_opb;     // multiplicand (mul) or divisor (div)
  logic [63:0] r_acc;     // mul: {partial, multiplier}; div: {remainder, quotient}
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_done;

  // Operand magnitudes; 0x80000000 negates to itself and reads as 2^31.
  logic        w_neg_a;
  logic        w_neg_b;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;

  assign w_neg_a = op[0] & a[31];
  assign w_neg_b = op[0] & b[31];
  assign w_a_mag = w_neg_a ? (32'd0 - a) : a;
  assign w_b_mag = w_neg_b ? (32'd0 - b) : b;

  // Multiply step: 33-bit add keeps the carry, then shift the whole
  // accumulator right so the next multiplier bit lands in bit 0.
  logic [32:0] w_mul_sum;
  logic [63:0] w_mul_next;

  assign w_mul_sum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opb} : 33'd0);
  assign w_mul_next = {w_mul_sum, r_acc[31:1]};

  // Restoring divide step: the shifted partial remainder can reach 33 bits,
  // so the trial compare is 33 bits wide. When it succeeds the difference is
  // below the divisor and fits in 32 bits.
  logic [32:0] w_div_shift;
  logic        w_div_ok;
  logic [31:0] w_div_diff;
  logic [63:0] w_div_next;

  assign w_div_shift = r_acc[63:31];
  assign w_div_ok    = (w_div_shift >= {1'b0, r_opb});
  assign w_div_diff  = w_div_shift[31:0] - r_opb;
  assign w_div_next  = {(w_div_ok ? w_div_diff : w_div_shift[31:0]),
                        r_acc[30:0], w_div_ok};

  // FIX-cycle sign correction. r_sa/r_sb are zero for unsigned ops, so no
  // negation ever happens there.
  logic [63:0] w_prod;
  logic [31:0] w_quo;
  logic [31:0] w_rem;
  logic        w_div_zero;
  logic [31:0] w_fix_hi;
  logic [31:0] w_fix_lo;

  assign w_prod     = (r_sa ^ r_sb) ? (64'd0 - r_acc) : r_acc;
  assign w_quo      = (r_sa ^ r_sb) ? (32'd0 - r_acc[31:0]) : r_acc[31:0];
  // Remainder takes the dividend's sign. On divide-by-zero the remainder is
  // |a|, so this also restores the original a into HI.
  assign w_rem      = r_sa ? (32'd0 - r_acc[63:32]) : r_acc[63:32];
  assign w_div_zero = (r_opb == 32'd0);
  assign w_fix_hi   = r_is_div ? w_rem : w_prod[63:32];
  assign w_fix_lo   = r_is_div ? (w_div_zero ? 32'hFFFF_FFFF : w_quo)
                               : w_prod[31:0];

  // State register.
  // NOTE: clocked state uses non-blocking (<=) so every flop samples the
  // pre-edge values of the others; blocking here would create order races.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic.
  // NOTE: w_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_CALC;
      S_CALC:  if (r_cnt == 5'd31) w_next = S_FIX;
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath and HI/LO.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= 5'd0;
      r_is_div <= 1'b0;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      r_opb    <= 32'd0;
      r_acc    <= 64'd0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            // start wins; any simultaneous move is dropped.
            r_cnt    <= 5'd0;
            r_is_div <= op[1];
            r_sa     <= w_neg_a;
            r_sb     <= w_neg_b;
            r_opb    <= op[1] ? w_b_mag : w_a_mag;
            r_acc    <= {32'd0, (op[1] ? w_a_mag : w_b_mag)};
          end else begin
            if (mthi) r_hi <= a;
            if (mtlo) r_lo <= a;
          end
        end
        S_CALC: begin
          r_cnt <= r_cnt + 5'd1;
          r_acc <= r_is_div ? w_div_next : w_mul_next;
        end
        S_FIX: begin
          r_hi   <= w_fix_hi;
          r_lo   <= w_fix_lo;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign hi   = r_hi;
  assign lo   = r_lo;
  assign busy = (r_state != S_IDLE);
  assign done = r_done;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit
// ----------------------------------------------------------------------------
// Directed self-checking bench for muldiv_unit. Expected HI/LO pairs are
// pushed to a scoreboard queue when an operation is started and popped when
// the DUT pulses done. Each operation also checks latency, busy length,
// busy/done exclusivity, HI/LO holding while busy and the done pulse width.
// Inputs change and outputs are sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        mthi;
  logic        mtlo;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string       tag;
    logic [63:0] exp;
  } sb_t;

  sb_t sb[$];

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  muldiv_unit dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .mthi  (mthi),
    .mtlo  (mtlo),
    .hi    (hi),
    .lo    (lo),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Start one operation and follow it to completion. with_mv raises
  // mthi/mtlo together with start; inj_cyc > 0 injects mthi plus a second
  // start in that cycle while busy. Both must be ignored.
  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [63:0] e, input string tag,
                       input bit with_mv, input int inj_cyc);
    int          cyc;
    int          bcyc;
    int          ovl;
    int          chg;
    bit          got;
    logic [31:0] hi0;
    logic [31:0] lo0;
    sb_t         item;
    cyc  = 0;
    bcyc = 0;
    ovl  = 0;
    chg  = 0;
    got  = 1'b0;
    hi0  = hi;
    lo0  = lo;
    sb.push_back('{tag, e});
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    mthi  = with_mv;
    mtlo  = with_mv;
    while (!got && cyc < 100) begin
      @(negedge clk);
      start = 1'b0;
      mthi  = 1'b0;
      mtlo  = 1'b0;
      cyc++;
      if (busy) bcyc++;
      if (busy && done) ovl++;
      if (done) got = 1'b1;
      else if (hi !== hi0 || lo !== lo0) chg++;
      if (cyc == inj_cyc) begin
        start = 1'b1;
        mthi  = 1'b1;
        op    = OP_DIVU;
        a     = 32'h0000_DEAD;
      end
    end
    check({tag, " done seen"}, 64'(got), 64'd1);
    item = sb.pop_front();
    check(item.tag, {hi, lo}, item.exp);
    check({tag, " latency"}, 64'(cyc), 64'd34);
    check({tag, " busy cycles"}, 64'(bcyc), 64'd33);
    check({tag, " busy&done overlap"}, 64'(ovl), 64'd0);
    check({tag, " hi/lo held while busy"}, 64'(chg), 64'd0);
    @(negedge clk);
    check({tag, " done width"}, 64'(done), 64'd0);
  endtask

  initial begin
    int n_done;
    reset = 1'b1;
    start = 1'b0;
    mthi  = 1'b0;
    mtlo  = 1'b0;
    op    = 2'b00;
    a     = 32'd0;
    b     = 32'd0;
    repeat (3) @(negedge clk);
    check("reset hi",   64'(hi),   64'd0);
    check("reset lo",   64'(lo),   64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    do_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "multu max", 1'b0, 0);
    do_op(OP_MULT,  32'hFFFF_FFFD, 32'd5,         64'hFFFF_FFFF_FFFF_FFF1, "mult -3*5", 1'b0, 0);
    do_op(OP_MULT,  32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, "mult min*min", 1'b0, 0);
    do_op(OP_DIV,   32'hFFFF_FFF9, 32'd2,         64'hFFFF_FFFF_FFFF_FFFD, "div -7/2", 1'b0, 0);
    do_op(OP_DIVU,  32'd5,         32'd0,         64'h0000_0005_FFFF_FFFF, "divu 5/0", 1'b0, 0);
    do_op(OP_DIV,   32'hFFFF_FFF9, 32'd0,         64'hFFFF_FFF9_FFFF_FFFF, "div -7/0", 1'b0, 0);
    do_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, "div min/-1", 1'b0, 0);

    // MTHI and MTLO together, then MTHI alone.
    a    = 32'h1234_5678;
    mthi = 1'b1;
    mtlo = 1'b1;
    @(negedge clk);
    mthi = 1'b0;
    mtlo = 1'b0;
    check("mthi+mtlo hi",   64'(hi),   64'h1234_5678);
    check("mthi+mtlo lo",   64'(lo),   64'h1234_5678);
    check("mthi+mtlo done", 64'(done), 64'd0);

    do_op(OP_MULTU, 32'd3, 32'd4, 64'h0000_0000_0000_000C, "multu 3*4 w/ inject", 1'b0, 10);
    do_op(OP_MULTU, 32'd6, 32'd7, 64'h0000_0000_0000_002A, "multu 6*7 start+moves", 1'b1, 0);

    a    = 32'hAAAA_5555;
    mthi = 1'b1;
    @(negedge clk);
    mthi = 1'b0;
    check("mthi only", {hi, lo}, 64'hAAAA_5555_0000_002A);

    do_op(OP_DIVU, 32'd100, 32'd7, 64'h0000_0002_0000_000E, "divu 100/7", 1'b0, 0);

    // Abort an operation with reset mid-flight.
    op    = OP_DIVU;
    a     = 32'd100;
    b     = 32'd7;
    start = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("mid-op busy before reset", 64'(busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort busy", 64'(busy), 64'd0);
    check("abort hi/lo", {hi, lo}, 64'd0);
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("abort no done", 64'(n_done), 64'd0);
    check("abort hi/lo stay", {hi, lo}, 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
